// File: rtl/adder_simd_pipe_pkg.sv
// Shared definitions for the pipelined SIMD adder/subtractor.
// Holds the operation encodings and the default datapath width.
package adder_simd_pipe_pkg;

   localparam int LEN_DATA = 64;

   localparam logic [1:0] ADD_OP_ADD  = 2'd0;
   localparam logic [1:0] ADD_OP_SUB  = 2'd1;
   localparam logic [1:0] ADD_OP_ADDS = 2'd2;
   localparam logic [1:0] ADD_OP_SUBS = 2'd3;

endpackage

// File: rtl/adder_simd_pipe_seg.sv
// Combinational ripple adder over a run of SB bytes with lane breaks.
// Ports: a/b bytes, start (byte begins a lane), cl (lane carry-in),
// ci (carry from the byte below the run), sum bytes, co per-byte carry.
module adder_seg #(
   parameter int SB = 4
) (
   input  logic [SB*8-1:0] a,
   input  logic [SB*8-1:0] b,
   input  logic [SB-1:0]   start,
   input  logic            cl,
   input  logic            ci,
   output logic [SB*8-1:0] sum,
   output logic [SB-1:0]   co
);

   logic c;

   always_comb begin
      c = ci;
      sum = '0;
      co = '0;
      for (int j = 0; j < SB; j++) begin
         if (start[j]) c = cl;
         {c, sum[j*8 +: 8]} = {1'b0, a[j*8 +: 8]}
                            + {1'b0, b[j*8 +: 8]}
                            + {8'd0, c};
         co[j] = c;
      end
   end

endmodule

// File: rtl/adder_simd_pipe.sv
// Pipelined WIDTH-bit SIMD add/sub with byte lanes and unsigned saturation.
// Ports: clk, rst (sync, low), en (stall), valid/op/a/b/cin/cmsk_n in;
// sum, cout (per byte), sat (per lane top), rdy out after STAGES cycles.
module adder_simd_pipe
   import adder_simd_pipe_pkg::*;
#(
   parameter int WIDTH  = LEN_DATA,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               valid,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [WIDTH/8-1:0] cmsk_n,
   output logic [WIDTH-1:0]   sum,
   output logic [WIDTH/8-1:0] cout,
   output logic [WIDTH/8-1:0] sat,
   output logic               rdy
);

   localparam int NB = WIDTH / 8;
   localparam int SB = NB / STAGES;
   localparam int SW = SB * 8;
   localparam int L  = STAGES - 1;

   if (WIDTH % 8 != 0 || STAGES < 1 || STAGES > NB || NB % STAGES != 0)
   begin : g_bad_cfg
      $error("adder_simd_pipe: illegal WIDTH/STAGES");
   end

   // x* : what enters stage k; r* : registered result of stage k
   logic [WIDTH-1:0] xa [STAGES], xb [STAGES], xs [STAGES];
   logic [NB-1:0]    xm [STAGES], xc [STAGES];
   logic [1:0]       xop [STAGES];
   logic             xcl [STAGES], xci [STAGES], xv [STAGES];

   logic [WIDTH-1:0] ra [STAGES], rb [STAGES], rs [STAGES];
   logic [NB-1:0]    rm [STAGES], rc [STAGES];
   logic [1:0]       rop [STAGES];
   logic             rcl [STAGES], rci [STAGES], rv [STAGES];

   logic [SW-1:0]    ss [STAGES];
   logic [SB-1:0]    sc [STAGES], st [STAGES];
   logic [WIDTH-1:0] ns [STAGES];
   logic [NB-1:0]    nc [STAGES];
   logic             nci [STAGES];

   logic [WIDTH-1:0] fs;
   logic [NB-1:0]    fc, fsat;
   logic [NB:0]      me;
   logic             lc, hit, adds, subs, sub_in;

   always_comb begin
      // b and the lane carry are inverted once at entry for subtraction
      sub_in = (op == ADD_OP_SUB) || (op == ADD_OP_SUBS);
      xa[0]  = a;
      xb[0]  = sub_in ? ~b : b;
      xs[0]  = '0;
      xc[0]  = '0;
      xm[0]  = cmsk_n;
      xop[0] = op;
      xcl[0] = sub_in ? ~cin : cin;
      xci[0] = 1'b0;
      xv[0]  = valid;
      for (int k = 1; k < STAGES; k++) begin
         xa[k]  = ra[k-1];
         xb[k]  = rb[k-1];
         xs[k]  = rs[k-1];
         xc[k]  = rc[k-1];
         xm[k]  = rm[k-1];
         xop[k] = rop[k-1];
         xcl[k] = rcl[k-1];
         xci[k] = rci[k-1];
         xv[k]  = rv[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         for (int j = 0; j < SB; j++) begin
            st[k][j] = (k * SB + j == 0) || !xm[k][k*SB + j];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      adder_seg #(.SB(SB)) u_seg (
         .a     (xa[k][k*SW +: SW]),
         .b     (xb[k][k*SW +: SW]),
         .start (st[k]),
         .cl    (xcl[k]),
         .ci    (xci[k]),
         .sum   (ss[k]),
         .co    (sc[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ns[k] = xs[k];
         ns[k][k*SW +: SW] = ss[k];
         nc[k] = xc[k];
         nc[k][k*SB +: SB] = sc[k];
         nci[k] = sc[k][SB-1];
      end
      fs   = ns[L];
      fc   = nc[L];
      fsat = '0;
      lc   = 1'b0;
      hit  = 1'b0;
      adds = (xop[L] == ADD_OP_ADDS);
      subs = (xop[L] == ADD_OP_SUBS);
      // me[i+1]==0 marks byte i as a lane top; walking down, lc holds
      // the carry of the lane the current byte belongs to
      me = {1'b0, xm[L]};
      for (int i = NB - 1; i >= 0; i--) begin
         if (!me[i+1]) lc = fc[i];
         hit = (adds & lc) | (subs & ~lc);
         fsat[i] = hit & ~me[i+1];
         if (hit) fs[i*8 +: 8] = adds ? 8'hFF : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) rv[k] <= 1'b0;
         sum  <= '0;
         cout <= '0;
         sat  <= '0;
         rdy  <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            ra[k]  <= xa[k];
            rb[k]  <= xb[k];
            rs[k]  <= ns[k];
            rc[k]  <= nc[k];
            rm[k]  <= xm[k];
            rop[k] <= xop[k];
            rcl[k] <= xcl[k];
            rci[k] <= nci[k];
            rv[k]  <= xv[k];
         end
         rdy <= xv[L];
         if (xv[L]) begin
            sum  <= fs;
            cout <= fc;
            sat  <= fsat;
         end
      end
   end

endmodule

// File: tb/tb_adder_simd_pipe.sv
// Self-checking bench for adder_simd_pipe (WIDTH=64, STAGES=2).
// Lane arithmetic reference plus a delay-line model of the pipeline.
module tb_adder_simd_pipe;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst, en, valid, cin;
   logic [1:0]  op;
   logic [63:0] a, b, sum;
   logic [7:0]  cmsk_n, cout, sat;
   logic        rdy;

   int checks = 0;
   int errors = 0;

   logic        dv [S];
   logic [63:0] ds [S];
   logic [7:0]  dc [S], dsat [S];
   logic        e_rdy;
   logic [63:0] e_sum;
   logic [7:0]  e_cout, e_sat;

   adder_simd_pipe #(.WIDTH(64), .STAGES(S)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .valid  (valid),
      .op     (op),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .cmsk_n (cmsk_n),
      .sum    (sum),
      .cout   (cout),
      .sat    (sat),
      .rdy    (rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Lane-level arithmetic on whole integers
   function automatic void ref_op(
      input  logic [1:0]  o,
      input  logic [63:0] x, y,
      input  logic        c,
      input  logic [7:0]  m,
      output logic [63:0] s,
      output logic [7:0]  co,
      output logic [7:0]  st);
      logic [8:0]   mx;
      logic [127:0] av, bv, r, mask, v;
      int lo, w;
      logic lane_c, is_sub;
      s = '0; co = '0; st = '0; lo = 0;
      mx = {1'b0, m};
      is_sub = o[0];
      for (int i = 0; i < 8; i++) begin
         if (!mx[i+1]) begin
            for (int j = lo; j <= i; j++) begin
               w = 8 * (j - lo + 1);
               mask = (128'd1 << w) - 128'd1;
               av = ({64'd0, x} >> (lo * 8)) & mask;
               bv = ({64'd0, y} >> (lo * 8)) & mask;
               if (is_sub) co[j] = (av >= bv + {127'd0, c});
               else begin
                  r = av + bv + {127'd0, c};
                  co[j] = r[w];
               end
               if (j == i) begin
                  v = is_sub ? (av - bv - {127'd0, c}) & mask
                             : (av + bv + {127'd0, c}) & mask;
                  lane_c = co[j];
                  if (o == 2'd2 && lane_c) begin
                     v = mask; st[i] = 1'b1;
                  end
                  if (o == 2'd3 && !lane_c) begin
                     v = '0; st[i] = 1'b1;
                  end
                  s = s | v[63:0] << (lo * 8);
               end
            end
            lo = i + 1;
         end
      end
   endfunction

   task automatic model_edge();
      logic [63:0] s;
      logic [7:0]  c, t;
      if (!rst) begin
         for (int k = 0; k < S; k++) dv[k] = 1'b0;
         e_rdy = 1'b0; e_sum = '0; e_cout = '0; e_sat = '0;
      end else if (en) begin
         for (int k = S - 1; k > 0; k--) begin
            dv[k] = dv[k-1]; ds[k] = ds[k-1];
            dc[k] = dc[k-1]; dsat[k] = dsat[k-1];
         end
         ref_op(op, a, b, cin, cmsk_n, s, c, t);
         dv[0] = valid; ds[0] = s; dc[0] = c; dsat[0] = t;
         e_rdy = dv[S-1];
         if (dv[S-1]) begin
            e_sum = ds[S-1]; e_cout = dc[S-1]; e_sat = dsat[S-1];
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ".rdy"}, {63'd0, rdy}, {63'd0, e_rdy});
      chk({tag, ".sum"}, sum, e_sum);
      chk({tag, ".cout"}, {56'd0, cout}, {56'd0, e_cout});
      chk({tag, ".sat"}, {56'd0, sat}, {56'd0, e_sat});
   endtask

   task automatic drive(input logic v, input logic [1:0] o,
                        input logic [63:0] x, y, input logic c,
                        input logic [7:0] m);
      valid = v; op = o; a = x; b = y; cin = c; cmsk_n = m;
   endtask

   initial begin
      for (int k = 0; k < S; k++) dv[k] = 1'b0;
      e_rdy = 1'b0; e_sum = '0; e_cout = '0; e_sat = '0;
      rst = 1'b0; en = 1'b1;
      drive(1'b1, 2'd0, 64'h1, 64'h2, 1'b0, 8'hFF);
      tick("reset0");
      valid = 1'b0;
      tick("reset1");
      chk("reset.sum", sum, 64'd0);
      chk("reset.rdy", {63'd0, rdy}, 64'd0);

      rst = 1'b1;
      drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 8'hFF);
      tick("fullc0");
      valid = 1'b0;
      chk("fullc.early", {63'd0, rdy}, 64'd0);
      tick("fullc1");
      chk("fullc.sum", sum, 64'd0);
      chk("fullc.cout", {56'd0, cout}, 64'hFF);
      chk("fullc.rdy", {63'd0, rdy}, 64'd1);

      drive(1'b1, 2'd0, 64'h1FF, 64'h1, 1'b0, 8'h00);
      tick("lanes0");
      valid = 1'b0;
      tick("lanes1");
      chk("lanes.sum", sum, 64'h100);
      chk("lanes.cout", {56'd0, cout}, 64'h01);

      drive(1'b1, 2'd3, 64'h3_0003, 64'h1_0005, 1'b0, 8'hAA);
      tick("subs0");
      valid = 1'b0;
      tick("subs1");
      chk("subs.sum", sum, 64'h2_0000);
      chk("subs.sat", {56'd0, sat}, 64'h02);

      drive(1'b1, 2'd2, 64'hFFF0, 64'h0020, 1'b0, 8'hAA);
      tick("stallA");
      drive(1'b1, 2'd1, 64'd100, 64'd7, 1'b1, 8'hFF);
      tick("stallB");
      valid = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) tick("stall");
      chk("stall.sumA", sum, 64'hFFFF);
      chk("stall.satA", {56'd0, sat}, 64'h02);
      en = 1'b1;
      tick("resume");
      chk("resume.sumB", sum, 64'd92);
      chk("resume.rdyB", {63'd0, rdy}, 64'd1);

      drive(1'b1, 2'd0, 64'd5, 64'd6, 1'b0, 8'hFF);
      tick("midrst0");
      valid = 1'b0; rst = 1'b0;
      tick("midrst1");
      rst = 1'b1;
      tick("midrst2");
      tick("midrst3");
      drive(1'b1, 2'd0, 64'd40, 64'd2, 1'b1, 8'hFF);
      tick("after0");
      valid = 1'b0;
      tick("after1");
      chk("after.sum", sum, 64'd43);

      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) != 0);
         en = ($urandom_range(0, 4) != 0);
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
